// File: rtl/rv32_mod_handshake_mem_responder.sv
// rv32_mod_handshake_mem_responder
// Word-addressed RAM acting as the responder on the core's req/ack/err bus.
// A request is captured in IDLE, held for a configurable number of wait
// states and answered with a one-cycle ack (with read data) or err.
// Optional macro RV32_HANDSHAKE_MEM_RANDOM_STALL_EN adds 0..3 pseudo-random
// extra wait states per access from an 8-bit Galois LFSR.
module rv32_mod_handshake_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h10000000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic        ack,
    output logic        err,
    output logic [31:0] data_o
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
    localparam logic [4:0]  WAIT_LD = 5'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [4:0]         r_cnt;
    logic [4:0]         w_cnt_nxt;
    logic [4:0]         w_wait_ld;
    logic               w_capture;
    logic               w_enter_resp;

    // Captured request (data path, no reset needed)
    logic               r_wr;
    logic [3:0]         r_be;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic               r_resp_err;
    logic [31:0]        r_data_o;
    logic [31:0]        r_mem [DEPTH_WORDS];

    // The access being answered: live inputs when going straight from IDLE
    // to RESP, otherwise the values captured at request time.
    logic               w_acc_wr;
    logic [3:0]         w_acc_be;
    logic [31:0]        w_acc_addr;
    logic [31:0]        w_acc_wdata;
    logic [31:0]        w_off;
    logic               w_acc_err;
    logic [IDX_W-1:0]   w_idx;
    logic               w_mem_we;

`ifdef RV32_HANDSHAKE_MEM_RANDOM_STALL_EN
    logic [7:0] r_lfsr;

    // Galois LFSR (taps 0xB8) free-running to pick extra wait states
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 8'h5A;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign w_wait_ld = WAIT_LD + {3'b000, r_lfsr[1:0]};
`else
    assign w_wait_ld = WAIT_LD;
`endif

    assign w_acc_wr    = (r_state == S_IDLE) ? wr     : r_wr;
    assign w_acc_be    = (r_state == S_IDLE) ? be     : r_be;
    assign w_acc_addr  = (r_state == S_IDLE) ? addr   : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? data_i : r_wdata;

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail range
    assign w_off     = w_acc_addr - BASE_ADDR;
    assign w_acc_err = (w_acc_addr[1:0] != 2'b00) || (w_acc_be == 4'b0000) ||
                       (w_off >= SPAN);
    assign w_idx     = w_off[IDX_W+1:2];

    // Reset gating keeps an access seen during reset from touching memory
    assign w_mem_we  = reset && w_enter_resp && !w_acc_err && w_acc_wr;

    // Next-state logic: capture, wait countdown with abort, single response
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_capture = 1'b1;
                    if (w_wait_ld == 5'd0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                        w_cnt_nxt    = 5'd0;
                    end else begin
                        w_state_nxt  = S_WAIT;
                        w_cnt_nxt    = w_wait_ld;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 5'd0;
                end else if (r_cnt <= 5'd1) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                    w_cnt_nxt    = 5'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    // Control state, response kind and read data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_resp_err <= 1'b0;
            r_data_o   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter_resp) begin
                r_resp_err <= w_acc_err;
                if (!w_acc_err && !w_acc_wr) begin
                    r_data_o <= r_mem[w_idx];
                end
            end
        end
    end

    // Hold the request fields so later input changes are ignored
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_wr    <= wr;
            r_be    <= be;
            r_addr  <= addr;
            r_wdata <= data_i;
        end
    end

    // Byte-masked write, committed as the response is issued
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ack    = (r_state == S_RESP) && !r_resp_err;
    assign err    = (r_state == S_RESP) &&  r_resp_err;
    assign data_o = r_data_o;

endmodule
